// File: rtl/inst_mem_pipe_pkg.sv
// Shared definitions for the instruction-memory responder.
// Default widths, the default response-entry layout and a sizing helper.
package inst_mem_pipe_pkg;

    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_OPAQ_BITS = 8;
    localparam int DEF_DEPTH     = 2;
    localparam int DEF_MEM_WORDS = 256;

    // Response entry at the default widths; the top rebuilds the same
    // layout from its own parameters.
    typedef struct packed {
        logic [DEF_DATA_BITS-1:0] data;
        logic [DEF_OPAQ_BITS-1:0] opaque;
    } resp_entry_t;

    // Width that can hold count + inflight (up to depth + 1) without wrap.
    function automatic int occ_bits(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/inst_mem_pipe_if.sv
// Fetch-side request/response channel of the instruction-memory responder.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload stable until that edge; valid never
// waits on ready. The receiver may drive ready combinationally.
interface inst_mem_pipe_if
    import inst_mem_pipe_pkg::*;
#(
    parameter int p_addr_bits = DEF_ADDR_BITS,
    parameter int p_data_bits = DEF_DATA_BITS,
    parameter int p_opaq_bits = DEF_OPAQ_BITS
);
    logic                   req_val;
    logic                   req_rdy;
    logic [p_addr_bits-1:0] req_addr;
    logic [p_opaq_bits-1:0] req_opaque;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [p_data_bits-1:0] resp_data;
    logic [p_opaq_bits-1:0] resp_opaque;

    // Fetch unit side.
    modport master (
        output req_val, req_addr, req_opaque, resp_rdy,
        input  req_rdy, resp_val, resp_data, resp_opaque
    );

    // Responder side.
    modport slave (
        input  req_val, req_addr, req_opaque, resp_rdy,
        output req_rdy, resp_val, resp_data, resp_opaque
    );
endinterface

// File: rtl/inst_mem_resp_fifo.sv
// Response FIFO: p_depth entries, head read straight from storage, with an
// occupancy count. Depth must be a power of two so pointers wrap naturally.
module inst_mem_resp_fifo
    import inst_mem_pipe_pkg::*;
#(
    parameter int p_width = DEF_DATA_BITS + DEF_OPAQ_BITS,
    parameter int p_depth = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [p_width-1:0]       push_data,
    input  logic                     pop,
    output logic [p_width-1:0]       head,
    output logic [$clog2(p_depth):0] count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(p_depth);

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    // Storage, pointers and count; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < p_depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(p_depth));
    assign empty = (count == '0);

    // The credit check upstream must make these impossible.
    push_to_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));
    pop_from_empty_a: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/inst_mem_pipe.sv
// Pipelined instruction-memory responder: accepts fetch requests, reads a
// synchronous SRAM, returns each word tagged with its opaque, in order.
// A request is only accepted when a FIFO slot is guaranteed for its reply.
// Optional build macro: INST_MEM_PIPE_STATS_EN adds stat_reqs/stat_stalls.
module inst_mem_pipe
    import inst_mem_pipe_pkg::*;
#(
    parameter int p_addr_bits = DEF_ADDR_BITS,
    parameter int p_data_bits = DEF_DATA_BITS,
    parameter int p_opaq_bits = DEF_OPAQ_BITS,
    parameter int p_depth     = DEF_DEPTH,
    parameter int p_mem_words = DEF_MEM_WORDS
) (
    input  logic                           clk,
    input  logic                           rst,
    inst_mem_pipe_if.slave                 fetch,
    output logic                           sram_en,
    output logic [$clog2(p_mem_words)-1:0] sram_addr,
    input  logic [p_data_bits-1:0]         sram_rdata
`ifdef INST_MEM_PIPE_STATS_EN
    ,
    output logic [31:0]                    stat_reqs,
    output logic [31:0]                    stat_stalls
`endif
);
    localparam int SA = $clog2(p_mem_words);
    localparam int CW = occ_bits(p_depth);

    typedef struct packed {
        logic [p_data_bits-1:0] data;
        logic [p_opaq_bits-1:0] opaque;
    } entry_t;

    logic                   accept;
    logic                   pop;
    logic                   inflight;
    logic [p_opaq_bits-1:0] inflight_opaque;
    entry_t                 push_entry;
    entry_t                 head_entry;
    logic [$clog2(p_depth):0] count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          occupancy;
    logic                   unused_addr;

    assign accept    = fetch.req_val && fetch.req_rdy;
    assign pop       = fetch.resp_val && fetch.resp_rdy;
    assign sram_en   = accept;
    // Byte offset dropped; bits above the SRAM index are ignored (index wraps).
    assign sram_addr = fetch.req_addr[SA+1:2];
    assign unused_addr = ^{fetch.req_addr[p_addr_bits-1:SA+2], fetch.req_addr[1:0], fifo_full};

    // Slots promised = buffered + reading - leaving this cycle.
    assign occupancy     = CW'(count) + CW'(inflight) - CW'(pop);
    assign fetch.req_rdy = (occupancy < CW'(p_depth));

    // Track the SRAM read in flight and the tag it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight        <= 1'b0;
            inflight_opaque <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_opaque <= fetch.req_opaque;
            end
        end
    end

    assign push_entry.data   = sram_rdata;
    assign push_entry.opaque = inflight_opaque;

    inst_mem_resp_fifo #(
        .p_width ($bits(entry_t)),
        .p_depth (p_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fetch.resp_val    = !fifo_empty;
    assign fetch.resp_data   = head_entry.data;
    assign fetch.resp_opaque = head_entry.opaque;

`ifdef INST_MEM_PIPE_STATS_EN
    // Saturating counters of accepted requests and stalled request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reqs   <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept && (stat_reqs != '1)) begin
                stat_reqs <= stat_reqs + 32'd1;
            end
            if (fetch.req_val && !fetch.req_rdy && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Line trace: "addr>opaque" on accept, "opaque<data" on response.
    function automatic string trace();
        string s;
        s = "";
        if (accept) begin
            s = $sformatf("%h>%h", fetch.req_addr, fetch.req_opaque);
        end
        if (pop) begin
            s = {s, (s.len() != 0) ? " " : "", $sformatf("%h<%h", fetch.resp_opaque, fetch.resp_data)};
        end
        return s;
    endfunction
`endif

endmodule
